// File: rtl/disp_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Glyphs are active-low a..g with a in bit 6 and g in bit 0.
package disp_pkg;

  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_R     = 4'd11;
  localparam logic [3:0] CODE_C     = 4'd12;
  localparam logic [3:0] CODE_A     = 4'd13;
  localparam logic [3:0] CODE_E     = 4'd14;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Index 15 first: blank, E, A, C, r, minus, 9 .. 0
  localparam logic [15:0][6:0] GLYPH = {
    7'b1111111, 7'b0110000, 7'b0001000, 7'b0110001,
    7'b1111010, 7'b1111110, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lz;
  } disp_val_t;

  localparam disp_val_t SHADOW_RST = '{digits: 16'hFFFF, dp: 4'h0, lz: 1'b0};

  function automatic logic [6:0] glyph(input logic [3:0] code);
    return GLYPH[code];
  endfunction

endpackage

// File: rtl/seg_encode.sv
// Purpose: 4-bit display code to active-low a..g pattern (dp handled by caller).
// Latency: combinational.
// Backpressure: none.
module seg_encode
  import disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = glyph(code);
  end

endmodule

// File: rtl/disp_scanner.sv
// Purpose: time-multiplexed 4-digit seven-segment driver with frame-synchronous value update.
// Latency: a load becomes visible at the next frame boundary; ack follows one cycle later.
// Backpressure: none; loads arriving before the boundary merge, newest wins, one ack.
module disp_scanner
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        lz_en,
  output logic        ack,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    cur, cur_nxt;
  logic          frame_end;

  disp_val_t     shadow, pend_buf, load_val;
  logic          pend;

  logic [3:1]    zero;
  logic [3:0]    lz_blank;
  logic [3:0]    cur_code;
  logic [6:0]    glyph_n;

  assign load_val = '{digits: digits, dp: dp_mask, lz: lz_en};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      cur   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cur   <= cur_nxt;
    end
  end

  // The slot counter restarts on every state change, so it times both phases.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    cur_nxt   = cur;
    frame_end = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          cur_nxt   = cur + 2'd1;
          frame_end = (cur == 2'd3);
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A load on the boundary cycle bypasses the pending buffer entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= SHADOW_RST;
      pend_buf <= '0;
      pend     <= 1'b0;
      ack      <= 1'b0;
    end else begin
      ack <= frame_end && (load || pend);
      if (frame_end) begin
        if (load) begin
          shadow <= load_val;
        end else if (pend) begin
          shadow <= pend_buf;
        end
        pend <= 1'b0;
      end else if (load) begin
        pend_buf <= load_val;
        pend     <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 1; i < 4; i++) begin
      zero[i] = (shadow.digits[4*i +: 4] == 4'h0);
    end
    lz_blank[3] = shadow.lz & zero[3];
    lz_blank[2] = lz_blank[3] & zero[2];
    lz_blank[1] = lz_blank[2] & zero[1];
    lz_blank[0] = 1'b0;
    cur_code    = lz_blank[cur] ? CODE_BLANK : shadow.digits[{cur, 2'b00} +: 4];
  end

  seg_encode u_seg_encode (
    .code  (cur_code),
    .seg_n (glyph_n)
  );

  // Outputs follow the next state; cur only advances when leaving SHOW, so it
  // already names the digit about to be shown. Shadow never changes during SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'hF;
      seg <= 8'hFF;
    end else if (state_nxt == SHOW) begin
      an  <= ~(4'b0001 << cur);
      seg <= {glyph_n, ~shadow.dp[cur]};
    end else begin
      an  <= 4'hF;
      seg <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_disp_scanner.sv
// Randomized + directed bench for disp_scanner with a frame-level reference model and scoreboard.
module tb_disp_scanner;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_mask = '0;
  logic        lz_en = 1'b0;
  logic        ack;
  logic [7:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  disp_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .digits  (digits),
    .dp_mask (dp_mask),
    .lz_en   (lz_en),
    .ack     (ack),
    .seg     (seg),
    .an      (an)
  );

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [7:0] seg;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Lit segments per code
  string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "g", "eg", "adef", "abcefg", "adefg", ""};

  // Model state: cycle index since reset release, shown value, pending value
  int          t;
  logic [15:0] sh_d, pb_d;
  logic [3:0]  sh_m, pb_m;
  logic        sh_z, pb_z, pend;

  function automatic logic [7:0] exp_glyph(input int code, input logic dp);
    logic [7:0] r;
    string      s;
    r = 8'hFF;
    s = lit[code];
    for (int k = 0; k < s.len(); k++) r[7 - (int'(s[k]) - 97)] = 1'b0;
    r[0] = ~dp;
    return r;
  endfunction

  function automatic exp_t expect_at(input int tt, input logic ak);
    exp_t e;
    int   p, s;
    logic blank;
    p = tt % FRAME;
    s = p / RD;
    e.t = tt; e.ack = ak; e.an = 4'hF; e.seg = 8'hFF;
    if (p % RD >= BC) begin
      e.an[s] = 1'b0;
      blank = sh_z && (s > 0);
      for (int j = s; j < 4; j++) if (sh_d[4*j +: 4] != 4'h0) blank = 1'b0;
      e.seg = exp_glyph(blank ? 15 : int'(sh_d[4*s +: 4]), sh_m[s]);
    end
    return e;
  endfunction

  task automatic model_step(input logic l, input logic [15:0] d, input logic [3:0] m, input logic z);
    int   p;
    logic ak;
    p = t % FRAME;
    ak = 1'b0;
    if (p == FRAME - 1) begin
      if (l) begin
        sh_d = d; sh_m = m; sh_z = z; pend = 1'b0; ak = 1'b1;
      end else if (pend) begin
        sh_d = pb_d; sh_m = pb_m; sh_z = pb_z; pend = 1'b0; ak = 1'b1;
      end
    end else if (l) begin
      pb_d = d; pb_m = m; pb_z = z; pend = 1'b1;
    end
    t++;
    sb.push_back(expect_at(t, ak));
  endtask

  task automatic cyc(input logic l, input logic [15:0] d, input logic [3:0] m, input logic z);
    @(negedge clk);
    load = l; digits = d; dp_mask = m; lz_en = z;
    model_step(l, d, m, z);
  endtask

  function automatic logic [15:0] rnd_digits();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic run_to(input int pp);
    while (t % FRAME != pp) idle(1);
  endtask

  task automatic chk_reset(input string name);
    vectors++;
    if (an !== 4'hF || seg !== 8'hFF || ack !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: an=%b seg=%b ack=%b, required an=1111 seg=11111111 ack=0", name, an, seg, ack);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    load = 1'b0;
    #1 chk_reset("reset_immediate");
    repeat (n) begin
      @(negedge clk);
      chk_reset("reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    t = 0; sh_d = 16'hFFFF; sh_m = 4'h0; sh_z = 1'b0;
    pend = 1'b0; pb_d = '0; pb_m = '0; pb_z = 1'b0;
    load = 1'b0;
    model_step(1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        mon_e = sb.pop_front();
        vectors++;
        if (an !== mon_e.an || seg !== mon_e.seg || ack !== mon_e.ack) begin
          miscompares++;
          $display("FAIL scan cycle %0d: an=%b seg=%b ack=%b, required an=%b seg=%b ack=%b",
                   mon_e.t, an, seg, ack, mon_e.an, mon_e.seg, mon_e.ack);
        end
      end
    end
  end

  initial begin
    do_reset(2);
    idle(48);

    // Mid-frame load of 1234 with dp on digit 1
    run_to(10); cyc(1'b1, 16'h1234, 4'b0010, 1'b0);
    run_to(31); idle(40);

    // Two loads merge into one ack
    run_to(5);  cyc(1'b1, 16'h1111, 4'b0000, 1'b0);
    run_to(20); cyc(1'b1, 16'h2222, 4'b0000, 1'b0);
    run_to(31); idle(33);

    // Boundary-cycle load overrides pending value
    run_to(10); cyc(1'b1, 16'h9999, 4'b0000, 1'b0);
    run_to(31); cyc(1'b1, 16'h0056, 4'b0000, 1'b0);
    idle(32);

    // Same with leading-zero blanking, then all zeros
    run_to(10); cyc(1'b1, 16'h9999, 4'b0000, 1'b0);
    run_to(31); cyc(1'b1, 16'h0056, 4'b0000, 1'b1);
    idle(32);
    run_to(31); cyc(1'b1, 16'h0000, 4'b0000, 1'b1);
    idle(32);
    run_to(31); cyc(1'b1, 16'h0000, 4'b1100, 1'b1);
    idle(32);

    // Reset during SHOW of digit 2 with a pending value
    run_to(3);  cyc(1'b1, 16'h8765, 4'b1111, 1'b0);
    run_to(20); do_reset(3);
    idle(70);

    repeat (1500) begin
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(0, 3));
      else cyc($urandom_range(0, 5) == 0, rnd_digits(), 4'($urandom), 1'($urandom));
    end

    @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
